// File: rtl/alu_exec_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_exec_pipe_if
// Purpose : bundles every non-clock signal of alu_exec_pipe: the upstream
//           operation handshake, the side channel to the external
//           combinational ALU, the downstream result handshake and the
//           status outputs (overflow sticky flag, retire counter).
// Modports: master - the environment (upstream, ALU, writeback, control)
//           slave  - alu_exec_pipe itself
// Params  : CNT_W - width of retire_cnt
// -----------------------------------------------------------------------------
interface alu_exec_pipe_if #(
    parameter int CNT_W = 16
);
    // upstream operation request
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [4:0]       in_tag;

    // external combinational ALU
    logic [2:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_f;
    logic [31:0]      alu_zf;
    logic [31:0]      alu_of;

    // downstream result
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic             out_zf;
    logic             out_of;
    logic [4:0]       out_tag;

    // status / control
    logic             of_sticky;
    logic             of_clr;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output alu_f, alu_zf, alu_of,
        output out_ready, of_clr,
        input  in_ready,
        input  alu_op, alu_a, alu_b,
        input  out_valid, out_f, out_zf, out_of, out_tag,
        input  of_sticky, retire_cnt
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  alu_f, alu_zf, alu_of,
        input  out_ready, of_clr,
        output in_ready,
        output alu_op, alu_a, alu_b,
        output out_valid, out_f, out_zf, out_of, out_tag,
        output of_sticky, retire_cnt
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// -----------------------------------------------------------------------------
// alu_exec_pipe
// Purpose : two-stage execute pipeline around an external combinational ALU.
//           S1 registers the accepted operation and drives the ALU directly;
//           S2 registers the ALU result, flags and destination tag for
//           writeback. Valid/ready handshakes on both sides, one operation per
//           cycle sustained, in-order retirement, an overflow sticky flag and a
//           wrapping retire counter.
// Ports   : clk   - sole clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - alu_exec_pipe_if.slave (handshakes, ALU side channel,
//                   result, of_sticky/of_clr, retire_cnt)
// Params  : CNT_W - retire counter width
// -----------------------------------------------------------------------------
module alu_exec_pipe #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_pipe_if.slave bus
);

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [4:0]       r_s1_tag;

    logic             r_out_valid;
    logic [31:0]      r_out_f;
    logic             r_out_zf;
    logic             r_out_of;
    logic [4:0]       r_out_tag;

    logic             r_of_sticky;
    logic [CNT_W-1:0] r_retire_cnt;

    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_retire;
    logic             w_unused_flags;

    // S1 may move on whenever S2 is empty or draining this edge; this makes
    // in_ready combinationally dependent on out_ready, which keeps full
    // throughput without a skid buffer.
    assign w_s1_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_retire   = r_out_valid && bus.out_ready;

    // Only bit 0 of each ALU flag word carries information.
    assign w_unused_flags = ^{bus.alu_zf[31:1], bus.alu_of[31:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'd0;
            r_s1_a     <= 32'd0;
            r_s1_b     <= 32'd0;
            r_s1_tag   <= 5'd0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= bus.in_op;
            r_s1_a     <= bus.in_a;
            r_s1_b     <= bus.in_b;
            r_s1_tag   <= bus.in_tag;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_f     <= 32'd0;
            r_out_zf    <= 1'b0;
            r_out_of    <= 1'b0;
            r_out_tag   <= 5'd0;
        end else if (r_s1_valid && w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_out_f     <= bus.alu_f;
            r_out_zf    <= bus.alu_zf[0];
            r_out_of    <= bus.alu_of[0];
            r_out_tag   <= r_s1_tag;
        end else if (w_retire) begin
            // Data is left in place; only the valid bit drops.
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_of_sticky  <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            // A retiring overflow beats a simultaneous clear.
            if (w_retire && r_out_of) begin
                r_of_sticky <= 1'b1;
            end else if (bus.of_clr) begin
                r_of_sticky <= 1'b0;
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.alu_op     = r_s1_op;
    assign bus.alu_a      = r_s1_a;
    assign bus.alu_b      = r_s1_b;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_f      = r_out_f;
    assign bus.out_zf     = r_out_zf;
    assign bus.out_of     = r_out_of;
    assign bus.out_tag    = r_out_tag;
    assign bus.of_sticky  = r_of_sticky;
    assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retire counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream operation request valid.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 in_op  input  3  ALU opcode (000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 SLL).
REQ-007 in_a, in_b  input  32 each  operands.
REQ-008 in_tag  input  5  destination register index, carried alongside the operation.
REQ-009 alu_op  output  3; alu_a, alu_b  output  32 each  operands driven to the combinational ALU.
REQ-010 alu_f  input  32  ALU result; alu_zf, alu_of  input  32 each  ALU flags, only bit 0 meaningful.
REQ-011 out_valid  output  1  result register holds a valid result.
REQ-012 out_ready  input  1  downstream (writeback) accepts the result.
REQ-013 out_f  output  32; out_zf, out_of  output  1 each; out_tag  output  5  registered result, flags and tag.
REQ-014 of_sticky  output  1  overflow seen since last clear; of_clr  input  1  synchronous clear.
REQ-015 retire_cnt  output  CNT_W  count of retired results.

Function
REQ-016 Two-stage pipeline SHALL exist: S1 (operand register: op, a, b, tag, s1_valid) and S2 (result register: out_*, out_valid).
REQ-017 Accept SHALL occur on an edge where in_valid && in_ready; S1 loads in_op/in_a/in_b/in_tag and sets s1_valid.
REQ-018 s1_adv SHALL be defined as !out_valid || out_ready; in_ready SHALL equal !s1_valid || s1_adv (combinational out_ready-to-in_ready path permitted).
REQ-019 alu_op/alu_a/alu_b SHALL be driven directly from the S1 registers, whether or not s1_valid is set.
REQ-020 On an edge with s1_valid && s1_adv, S2 SHALL capture alu_f, alu_zf[0], alu_of[0], S1 tag, and set out_valid; upper 31 flag bits ignored.
REQ-021 If s1_adv is high and no accept occurs on that edge, s1_valid SHALL clear; if s1_adv and accept coincide, S1 reloads with the new operation (back-to-back).
REQ-022 If out_valid && out_ready and s1_valid is low, out_valid SHALL clear on that edge.
REQ-023 Latency: operation accepted at edge N SHALL appear on out_* with out_valid high after edge N+1; sustained throughput one operation per cycle while out_ready is high.
REQ-024 Stall (out_valid && !out_ready): out_* and out_tag SHALL hold stable, S1 holds, in_ready = !s1_valid; no operation lost or duplicated.
REQ-025 Retire = out_valid && out_ready at an edge; retire_cnt SHALL increment by 1 per retire and wrap from 2^CNT_W-1 to 0.
REQ-026 of_sticky SHALL set on a retire with out_of = 1 and clear on of_clr; set and clear on the same edge: set wins.
REQ-027 Results SHALL retire in acceptance order; out_tag always matches the operation whose result is on out_f.

Reset
REQ-028 While rst_n low: s1_valid, out_valid, out_f, out_zf, out_of, out_tag, of_sticky, retire_cnt, S1 registers (hence alu_op/alu_a/alu_b) SHALL be 0, asynchronously.
REQ-029 in_ready SHALL be 1 during and immediately after reset.
REQ-030 Reset asserted mid-operation SHALL discard any S1/S2 contents; no result from before reset may retire after it.

Verification
REQ-031 Single op: accept ADD a=5 b=7 tag=3, out_ready=1 -> next cycle out_valid=1, out_f=12, out_zf=0, out_of=0, out_tag=3, retire_cnt=1.
REQ-032 Back-to-back: SUB 9-9, then ADD 0x7FFFFFFF+1, then SLT 1<2 on consecutive cycles -> three consecutive results (0, ZF=1), (0x80000000, OF=1), (1), of_sticky=1 after second.
REQ-033 Backpressure: out_ready=0 for 4 cycles with two ops sent -> in_ready drops after second accept, out_* stable, both results retire in order once out_ready=1.
REQ-034 Sticky collision: retire with out_of=1 on same edge as of_clr=1 -> of_sticky=1; of_clr next cycle with no overflow -> 0.
REQ-035 Counter wrap (CNT_W=4): 17 retires -> retire_cnt=1.
REQ-036 Reset mid-stall: out_valid=1, s1_valid=1, pulse rst_n low -> all outputs 0, in_ready=1, no stale result after release.
